// File: rtl/alu_issue_ctrl_if.sv
// Command channel from instruction decode into the ALU issue controller.
// A command transfers on a rising edge where cmd_valid && cmd_ready; payload is sampled only then.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs;
  logic [2:0] cmd_rt;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    output cmd_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues register-file operands to an external combinational ALU, waits EXEC_CYCLES,
// then writes the result back and latches the flags. Sequence: IDLE -> EXEC -> WB -> IDLE.
module alu_issue_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int REG_COUNT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_ctrl_if.slave      cmd,
  input  logic                 ld_en,
  input  logic [2:0]           ld_addr,
  input  logic [31:0]          ld_data,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_op,
  input  logic [31:0]          alu_result,
  input  logic                 alu_v,
  input  logic                 alu_c,
  input  logic                 alu_z,
  input  logic                 alu_s,
  output logic [3:0]           flags,
  output logic                 done,
  output logic                 div_err,
  input  logic [2:0]           dbg_addr,
  output logic [31:0]          dbg_data,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t          state, state_n;
  logic [31:0]     rf [REG_COUNT];
  logic [CW-1:0]   cnt;
  logic [2:0]      rd_q;
  logic [31:0]     res_q;
  logic [3:0]      flg_q;
  logic            dz_q;
  logic            accept;
  logic            exec_last;

  assign exec_last = (cnt == CW'(EXEC_CYCLES - 1));
  assign accept    = (state == IDLE) && cmd.cmd_valid && !ld_en;
  assign dbg_data  = (dbg_addr == 3'd0) ? 32'd0 : rf[dbg_addr];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    cmd.cmd_ready = 1'b0;
    done          = 1'b0;
    div_err       = 1'b0;
    case (state)
      IDLE: begin
        // a direct load always wins the cycle over a pending command
        cmd.cmd_ready = !ld_en;
        if (accept) state_n = EXEC;
      end
      EXEC: begin
        if (exec_last) state_n = WB;
      end
      WB: begin
        done    = 1'b1;
        div_err = dz_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_q   <= '0;
      cnt    <= '0;
      res_q  <= '0;
      flg_q  <= '0;
      dz_q   <= 1'b0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_en) begin
            if (ld_addr != 3'd0) rf[ld_addr] <= ld_data;
          end else if (cmd.cmd_valid) begin
            alu_a  <= rf[cmd.cmd_rs];
            alu_b  <= rf[cmd.cmd_rt];
            alu_op <= cmd.cmd_op;
            rd_q   <= cmd.cmd_rd;
            cnt    <= '0;
          end
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (exec_last) begin
            res_q <= alu_result;
            flg_q <= {alu_v, alu_c, alu_z, alu_s};
            dz_q  <= ((alu_op == 3'd3) || (alu_op == 3'd7)) && (alu_b == 32'd0);
          end
        end
        WB: begin
          // a suppressed divide leaves both the register file and flags untouched
          if (!dz_q) begin
            if (rd_q != 3'd0) rf[rd_q] <= res_q;
            flags <= flg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
